// File: rtl/hazard_detection_unit.sv
// Hazard detection for a classic 5-stage pipeline with branches resolved in ID.
// Keeps shadow copies of the EX and MEM destination/control fields and raises
// load-use and branch-operand stalls, IF/ID flushes, and two saturating
// performance counters (stall cycles, flush cycles).
//
// Control contract (single definition for all stall/flush signals):
//   Data_Hazard is active-low.  While it is 0, fetch holds PC and IF/ID
//   (pc_write = if_id_write = 0), decode re-presents the same id_* fields
//   next cycle, and a bubble is inserted into EX.  Control_Hazard = 1 means
//   the IF/ID contents are discarded; it is never raised during a stall,
//   because a branch compare made during a stall used stale operands.
module hazard_detection_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic                  id_branch_taken,
  input  logic [REG_ADDR_W-1:0] id_dest_reg,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  output logic                  Data_Hazard,
  output logic                  Control_Hazard,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Shadow pipeline state for the instructions in EX and MEM.
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;
  logic [CNT_W-1:0]      flush_count_q, flush_count_d;

  logic match_ex;
  logic match_mem;
  logic stall_load_use;
  logic stall_br_ex;
  logic stall_br_mem;
  logic stall;
  logic flush;

  // Operand matches of the ID instruction against EX/MEM destinations; $0 never matches.
  always_comb begin
    match_ex  = (ex_dest_q != '0) &&
                ((id_uses_rs && (ex_dest_q == id_rs)) ||
                 (id_uses_rt && (ex_dest_q == id_rt)));
    match_mem = (mem_dest_q != '0) &&
                ((id_uses_rs && (mem_dest_q == id_rs)) ||
                 (id_uses_rt && (mem_dest_q == id_rt)));
  end

  // Stall/flush decision and the externally visible control outputs.
  always_comb begin
    stall_load_use = ex_mem_read_q && ex_reg_write_q && match_ex;
    stall_br_ex    = id_branch && ex_reg_write_q && match_ex;
    stall_br_mem   = id_branch && mem_reg_write_q && match_mem;
    stall          = stall_load_use || stall_br_ex || stall_br_mem;
    // A stall overrides a taken branch: its compare saw stale operands and
    // the branch is re-evaluated once the stall clears.
    flush          = (id_jump || (id_branch && id_branch_taken)) && !stall;
    Data_Hazard    = !stall;
    pc_write       = !stall;
    if_id_write    = !stall;
    Control_Hazard = flush;
    stall_count    = stall_count_q;
    flush_count    = flush_count_q;
  end

  // Next shadow state: bubbles are gated here rather than trusted from decode.
  always_comb begin
    ex_dest_d       = id_dest_reg;
    ex_mem_read_d   = id_mem_read && !stall;
    ex_reg_write_d  = id_reg_write && !stall && !flush;
    mem_dest_d      = ex_dest_q;
    mem_reg_write_d = ex_reg_write_q;
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
    if (flush && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_dest_q       <= '0;
      ex_mem_read_q   <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      mem_dest_q      <= '0;
      mem_reg_write_q <= 1'b0;
      stall_count_q   <= '0;
      flush_count_q   <= '0;
    end else begin
      ex_dest_q       <= ex_dest_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_reg_write_q  <= ex_reg_write_d;
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      stall_count_q   <= stall_count_d;
      flush_count_q   <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit.  Inputs change at the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// A second instance with a 4-bit counter width exercises counter saturation.
module tb_hazard_detection_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_branch;
  logic       id_jump;
  logic       id_branch_taken;
  logic [4:0] id_dest_reg;
  logic       id_mem_read;
  logic       id_reg_write;

  logic        Data_Hazard;
  logic        Control_Hazard;
  logic        pc_write;
  logic        if_id_write;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  logic        s_dh;
  logic        s_ch;
  logic        s_pcw;
  logic        s_ifw;
  logic [3:0]  s_stall_count;
  logic [3:0]  s_flush_count;

  int n_cmp;
  int n_bad;

  hazard_detection_unit u_dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_branch       (id_branch),
    .id_jump         (id_jump),
    .id_branch_taken (id_branch_taken),
    .id_dest_reg     (id_dest_reg),
    .id_mem_read     (id_mem_read),
    .id_reg_write    (id_reg_write),
    .Data_Hazard     (Data_Hazard),
    .Control_Hazard  (Control_Hazard),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  hazard_detection_unit #(.REG_ADDR_W(5), .CNT_W(4)) u_sat (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_branch       (id_branch),
    .id_jump         (id_jump),
    .id_branch_taken (id_branch_taken),
    .id_dest_reg     (id_dest_reg),
    .id_mem_read     (id_mem_read),
    .id_reg_write    (id_reg_write),
    .Data_Hazard     (s_dh),
    .Control_Hazard  (s_ch),
    .pc_write        (s_pcw),
    .if_id_write     (s_ifw),
    .stall_count     (s_stall_count),
    .flush_count     (s_flush_count)
  );

  // Clock and power-on reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_branch = 0; id_jump = 0; id_branch_taken = 0;
    id_dest_reg = '0; id_mem_read = 0; id_reg_write = 0;
  endtask

  // Present one ID instruction at the falling edge, then wait 1 ns to sample.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic br, input logic jp, input logic tk,
                     input logic [4:0] dst, input logic mr, input logic rw);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_branch = br; id_jump = jp; id_branch_taken = tk;
    id_dest_reg = dst; id_mem_read = mr; id_reg_write = rw;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL rst_dh: got %b want 1", Data_Hazard); end
    n_cmp++; if (Control_Hazard !== 1'b0) begin n_bad++; $display("FAIL rst_ch: got %b want 0", Control_Hazard); end
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_bad++; $display("FAIL rst_en: got %b want 11", {pc_write, if_id_write}); end
    n_cmp++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_count, flush_count); end
    // Build up a nonzero stall count, then re-create a stall and reset mid-cycle.
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd2, 1, 1);   // lw $2
    cyc(5'd2, 5'd4, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // add $3,$2,$4 (stalls)
    cyc(5'd2, 5'd4, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // re-presented
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL rst_precount: got %0d want 1", stall_count); end
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd2, 1, 1);   // lw $2
    cyc(5'd2, 5'd4, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // add $3,$2,$4
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL rst_prestall: got %b want 0", Data_Hazard); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL rst_mid_dh: got %b want 1", Data_Hazard); end
    n_cmp++; if (Control_Hazard !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ch: got %b want 0", Control_Hazard); end
    n_cmp++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_count, flush_count); end
    // Release reset with the add still presented: EX/MEM are empty, no stall.
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL rst_post_dh: got %b want 1", Data_Hazard); end
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd2, 1, 1);   // lw $2
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL lu_lw_dh: got %b want 1", Data_Hazard); end
    cyc(5'd2, 5'd4, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // add $3,$2,$4
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL lu_dh: got %b want 0", Data_Hazard); end
    n_cmp++; if ({pc_write, if_id_write} !== 2'b00) begin n_bad++; $display("FAIL lu_en: got %b want 00", {pc_write, if_id_write}); end
    cyc(5'd2, 5'd4, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // re-presented
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL lu_second_dh: got %b want 1", Data_Hazard); end
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", stall_count); end
    idle_cyc();
    n_cmp++; if (stall_count !== 16'd1 || flush_count !== 16'd0) begin n_bad++; $display("FAIL lu_count_hold: got %0d/%0d want 1/0", stall_count, flush_count); end
  endtask

  task automatic test_branch_ex();
    do_reset();
    cyc(5'd1, 5'd1, 1, 1, 0, 0, 0, 5'd5, 0, 1);   // add $5,$1,$1
    cyc(5'd5, 5'd6, 1, 1, 1, 0, 1, 5'd0, 0, 0);   // beq $5,$6 taken
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b00) begin n_bad++; $display("FAIL br1_c1: got DH,CH=%b want 00", {Data_Hazard, Control_Hazard}); end
    cyc(5'd5, 5'd6, 1, 1, 1, 0, 1, 5'd0, 0, 0);
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b00) begin n_bad++; $display("FAIL br1_c2: got DH,CH=%b want 00", {Data_Hazard, Control_Hazard}); end
    cyc(5'd5, 5'd6, 1, 1, 1, 0, 1, 5'd0, 0, 0);
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b11) begin n_bad++; $display("FAIL br1_c3: got DH,CH=%b want 11", {Data_Hazard, Control_Hazard}); end
    idle_cyc();
    n_cmp++; if (Control_Hazard !== 1'b0) begin n_bad++; $display("FAIL br1_after_ch: got %b want 0", Control_Hazard); end
    n_cmp++; if (stall_count !== 16'd2 || flush_count !== 16'd1) begin n_bad++; $display("FAIL br1_counts: got %0d/%0d want 2/1", stall_count, flush_count); end
  endtask

  task automatic test_branch_distance();
    // Producer two ahead: one stall, branch not taken.
    do_reset();
    cyc(5'd1, 5'd1, 1, 1, 0, 0, 0, 5'd7, 0, 1);   // add $7
    idle_cyc();                                    // nop
    cyc(5'd8, 5'd7, 1, 1, 1, 0, 0, 5'd0, 0, 0);   // beq $8,$7
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL br2_c1: got %b want 0", Data_Hazard); end
    cyc(5'd8, 5'd7, 1, 1, 1, 0, 0, 5'd0, 0, 0);
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b10) begin n_bad++; $display("FAIL br2_c2: got DH,CH=%b want 10", {Data_Hazard, Control_Hazard}); end
    // Producer three ahead: no stall, taken branch flushes at once.
    cyc(5'd1, 5'd1, 1, 1, 0, 0, 0, 5'd9, 0, 1);   // add $9
    idle_cyc();
    idle_cyc();
    cyc(5'd9, 5'd0, 1, 1, 1, 0, 1, 5'd0, 0, 0);   // beq $9,$0 taken
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b11) begin n_bad++; $display("FAIL br3: got DH,CH=%b want 11", {Data_Hazard, Control_Hazard}); end
    idle_cyc();
    n_cmp++; if (stall_count !== 16'd1 || flush_count !== 16'd1) begin n_bad++; $display("FAIL br_dist_counts: got %0d/%0d want 1/1", stall_count, flush_count); end
    // Load feeding a branch directly: two stalls, like an ALU producer.
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd4, 1, 1);   // lw $4
    cyc(5'd4, 5'd4, 1, 1, 1, 0, 0, 5'd0, 0, 0);   // beq $4,$4
    cyc(5'd4, 5'd4, 1, 1, 1, 0, 0, 5'd0, 0, 0);
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL br_lw_c2: got %b want 0", Data_Hazard); end
    cyc(5'd4, 5'd4, 1, 1, 1, 0, 0, 5'd0, 0, 0);
    n_cmp++; if (Data_Hazard !== 1'b1 || stall_count !== 16'd3) begin n_bad++; $display("FAIL br_lw_c3: got DH=%b cnt=%0d want 1/3", Data_Hazard, stall_count); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 1);   // lw $0
    cyc(5'd0, 5'd0, 1, 1, 0, 0, 0, 5'd3, 0, 1);   // add $3,$0,$0
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL r0_dh: got %b want 1", Data_Hazard); end
    idle_cyc();
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL r0_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_jump();
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd2, 1, 1);   // lw $2
    cyc(5'd2, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 0);   // j, rs field happens to be 2
    n_cmp++; if ({Data_Hazard, Control_Hazard} !== 2'b11) begin n_bad++; $display("FAIL jmp: got DH,CH=%b want 11", {Data_Hazard, Control_Hazard}); end
    idle_cyc();
    n_cmp++; if (stall_count !== 16'd0 || flush_count !== 16'd1) begin n_bad++; $display("FAIL jmp_counts: got %0d/%0d want 0/1", stall_count, flush_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd2, 1, 1);   // lw $2
    cyc(5'd2, 5'd0, 1, 0, 0, 0, 0, 5'd3, 1, 1);   // lw $3,0($2)
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL b2b_c1: got %b want 0", Data_Hazard); end
    cyc(5'd2, 5'd0, 1, 0, 0, 0, 0, 5'd3, 1, 1);
    n_cmp++; if (Data_Hazard !== 1'b1) begin n_bad++; $display("FAIL b2b_c2: got %b want 1", Data_Hazard); end
    cyc(5'd1, 5'd3, 1, 1, 0, 0, 0, 5'd4, 0, 1);   // add $4,$1,$3
    n_cmp++; if (Data_Hazard !== 1'b0) begin n_bad++; $display("FAIL b2b_c3: got %b want 0", Data_Hazard); end
    cyc(5'd1, 5'd3, 1, 1, 0, 0, 0, 5'd4, 0, 1);
    n_cmp++; if (Data_Hazard !== 1'b1 || stall_count !== 16'd2) begin n_bad++; $display("FAIL b2b_c4: got DH=%b cnt=%0d want 1/2", Data_Hazard, stall_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    // Each round: producer of $5, then a dependent branch stalling twice.
    for (int i = 0; i < 20; i++) begin
      cyc(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd5, 0, 1);
      cyc(5'd5, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 0);
      cyc(5'd5, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 0);
      if (i == 5) begin
        idle_cyc();
        n_cmp++; if (s_stall_count !== 4'd12) begin n_bad++; $display("FAIL sat_mid: got %0d want 12", s_stall_count); end
      end
    end
    idle_cyc();
    n_cmp++; if (s_stall_count !== 4'hF) begin n_bad++; $display("FAIL sat_stall: got %h want f", s_stall_count); end
    n_cmp++; if (stall_count !== 16'd40) begin n_bad++; $display("FAIL sat_wide: got %0d want 40", stall_count); end
    for (int i = 0; i < 20; i++) begin
      cyc(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 0);   // j
    end
    idle_cyc();
    n_cmp++; if (s_flush_count !== 4'hF || flush_count !== 16'd20) begin n_bad++; $display("FAIL sat_flush: got %h/%0d want f/20", s_flush_count, flush_count); end
    n_cmp++; if (s_stall_count !== 4'hF) begin n_bad++; $display("FAIL sat_hold: got %h want f", s_stall_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_ex();
    test_branch_distance();
    test_reg_zero();
    test_jump();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline hazard detector that produces the stall and flush controls consumed by the decode stage (`Data_Hazard`, `Control_Hazard`) and by fetch (`pc_write`, `if_id_write`). It keeps its own shadow copies of the destination-register and control fields for the instructions in EX and MEM, captured from decode's outputs every cycle. From those it detects load-use hazards and branch-operand hazards; branches are resolved in ID with no forwarding into ID. Two saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-address width
- `CNT_W`, 16, performance-counter width

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high
- `id_rs`  in  REG_ADDR_W  decode instr[25:21]
- `id_rt`  in  REG_ADDR_W  decode instr[20:16]
- `id_uses_rs`  in  1  decode instruction reads rs
- `id_uses_rt`  in  1  decode instruction reads rt (R-type, beq, sw)
- `id_branch`  in  1  decode instruction is beq
- `id_jump`  in  1  decode instruction is j
- `id_branch_taken`  in  1  decode branch-compare result
- `id_dest_reg`  in  REG_ADDR_W  decode destination register
- `id_mem_read`  in  1  decode mem_read (post-bubble)
- `id_reg_write`  in  1  decode reg_write (post-bubble)
- `Data_Hazard`  out  1  ACTIVE-LOW: 0 = stall; decode bubbles when 0
- `Control_Hazard`  out  1  1 = flush IF/ID; decode bubbles when 1
- `pc_write`  out  1  PC update enable
- `if_id_write`  out  1  IF/ID register enable
- `stall_count`  out  CNT_W  saturating count of stall cycles
- `flush_count`  out  CNT_W  saturating count of flush cycles

## Operation
- Shadow registers:
  - `ex_dest`, `ex_mem_read`, `ex_reg_write` load each posedge from `id_dest_reg`, `id_mem_read & ~stall`, `id_reg_write & ~stall & ~Control_Hazard`.
  - `mem_dest`, `mem_reg_write` load from the ex_* registers.
  - The unit gates bubbles itself and does not rely on decode's gating.
- Match functions (register 0 never matches):
  - `m(d) = (d != 0) & ((id_uses_rs & d == id_rs) | (id_uses_rt & d == id_rt))`
- Stall conditions (combinational, `stall` = OR of all three):
  - Load-use: `ex_mem_read & ex_reg_write & m(ex_dest)`
  - Branch on EX result: `id_branch & ex_reg_write & m(ex_dest)`
  - Branch on MEM result: `id_branch & mem_reg_write & m(mem_dest)`
- WB-stage writes are not tracked. The register file returns same-cycle write data.
- Outputs:
  - `Data_Hazard = ~stall`
  - `pc_write = if_id_write = ~stall`
  - `Control_Hazard = (id_jump | (id_branch & id_branch_taken)) & ~stall`
- Simultaneous stall and taken branch: stall wins. `Control_Hazard` stays 0 because the compare used stale operands. The branch is re-evaluated after the stall.
- Jump: no operands (`id_uses_rs = id_uses_rt = 0`), so it never stalls and flushes in the cycle it is in ID.
- Counters:
  - `stall_count` increments each cycle `stall = 1`.
  - `flush_count` increments each cycle `Control_Hazard = 1`.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset (asynchronous, immediate): all shadow registers and both counters cleared. Outputs then settle to `Data_Hazard = 1`, `Control_Hazard = 0` (with `id_*` low), `pc_write = if_id_write = 1`, counts 0.
- Reset mid-stall: stall drops within the reset assertion. The first post-reset cycle sees empty EX/MEM.
- Latency: detection is combinational from `id_*` and the shadows, so stall/flush applies in the same cycle. Shadows update one posedge later.
- Load-use: exactly 1 stall cycle.
- Branch dependent on the instruction immediately ahead: 2 stall cycles (EX match, then MEM match), load or ALU alike.
- Branch dependent on the instruction two ahead: 1 stall cycle.
- Branch dependent on the instruction three ahead: 0 stall cycles.
- During a stall the stalled instruction re-presents unchanged `id_*`. A bubble enters EX.

## Test plan
- Reset asserted mid-cycle with `id_*` active -> `Data_Hazard = 1`, `Control_Hazard = 0`, counts 0 immediately.
- `lw $2` then `add $3,$2,$4` -> `Data_Hazard = 0` for exactly 1 cycle, `stall_count = 1`, no second stall.
- `add $5,$1,$1` then `beq $5,$6` (taken) -> 2 stall cycles, then `Control_Hazard = 1` for 1 cycle; `stall_count = 2`, `flush_count = 1`.
- `lw $0` then `add $3,$0,$0` -> no stall (register 0).
- `j` following `lw $2` with `id_rs = 2`, `id_uses_rs = 0` -> no stall, `Control_Hazard = 1` same cycle.
- Force 2^16 + 3 stall cycles -> `stall_count` holds `16'hFFFF`.
